// File: rtl/prm_pkg.sv
// Shared definitions for the PRM edge sweeper: configuration code geometry,
// FSM state encoding and the joint field-slice helper.
package prm_pkg;

    localparam int JBITS  = 3;
    localparam int NJOINT = 5;
    localparam int CODE_W = JBITS * NJOINT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [JBITS-1:0] joint_field(input logic [CODE_W-1:0] code,
                                                     input int                j);
        return code[j*JBITS +: JBITS];
    endfunction

endpackage

// File: rtl/prm_edge_sweep_if.sv
// Request/result handshake bundle between an edge requester and the sweeper.
interface prm_edge_sweep_if #(
    parameter int NUM_OBS = 8
) ();

    logic                        req_valid;
    logic                        req_ready;
    logic [prm_pkg::CODE_W-1:0]  req_start;
    logic [prm_pkg::CODE_W-1:0]  req_end;
    logic                        res_valid;
    logic                        res_ready;
    logic                        res_blocked;
    logic [2:0]                  res_step;
    logic [NUM_OBS-1:0]          res_mask;

    modport master (
        output req_valid, req_start, req_end, res_ready,
        input  req_ready, res_valid, res_blocked, res_step, res_mask
    );

    modport slave (
        input  req_valid, req_start, req_end, res_ready,
        output req_ready, res_valid, res_blocked, res_step, res_mask
    );

endinterface

// File: rtl/prm_joint_step.sv
// Moves one joint index a single count toward its target, saturating at the target.
module prm_joint_step #(
    parameter int W = 3
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] tgt,
    output logic [W-1:0] nxt,
    output logic         eq
);

    always_comb begin
        eq = (cur == tgt);
        if (cur < tgt) begin
            nxt = cur + 1'b1;
        end else if (cur > tgt) begin
            nxt = cur - 1'b1;
        end else begin
            nxt = cur;
        end
    end

endmodule

// File: rtl/prm_edge_sweep.sv
// Walks a configuration-space edge one sample per cycle, presenting each sample
// to an external combinational checker bank and reporting the first collision.
module prm_edge_sweep #(
    parameter int NUM_OBS = 8,
    parameter int JBITS   = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    prm_edge_sweep_if.slave            bus,
    output logic [prm_pkg::CODE_W-1:0] sample_code,
    input  logic [NUM_OBS-1:0]         chk_mask
);

    import prm_pkg::*;

    state_t              state;
    state_t              state_nxt;
    logic [CODE_W-1:0]   target;
    logic [CODE_W-1:0]   code_nxt;
    logic [2:0]          step;
    logic [NJOINT-1:0]   joint_eq;
    logic                accept;
    logic                finish;
    logic                adv;
    logic                hit;
    logic                reached;

    for (genvar j = 0; j < NJOINT; j++) begin : g_joint
        prm_joint_step #(.W(JBITS)) u_joint (
            .cur (joint_field(sample_code, j)),
            .tgt (joint_field(target, j)),
            .nxt (code_nxt[j*JBITS +: JBITS]),
            .eq  (joint_eq[j])
        );
    end

    // The checker bank sees sample_code directly, so its verdict for the
    // current sample is available in the same cycle.
    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        finish        = 1'b0;
        adv           = 1'b0;
        bus.req_ready = 1'b0;
        bus.res_valid = 1'b0;
        hit           = |chk_mask;
        reached       = &joint_eq;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept    = 1'b1;
                    state_nxt = SWEEP;
                end
            end
            SWEEP: begin
                if (hit || reached) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    adv = 1'b1;
                end
            end
            DONE: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A collision wins over reaching the end when both land on one sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_code     <= '0;
            target          <= '0;
            step            <= '0;
            bus.res_blocked <= 1'b0;
            bus.res_step    <= '0;
            bus.res_mask    <= '0;
        end else if (accept) begin
            sample_code <= bus.req_start;
            target      <= bus.req_end;
            step        <= '0;
        end else if (finish) begin
            bus.res_blocked <= hit;
            bus.res_step    <= step;
            bus.res_mask    <= hit ? chk_mask : '0;
        end else if (adv) begin
            sample_code <= code_nxt;
            step        <= step + 3'd1;
        end
    end

endmodule

// File: tb/tb_prm_edge_sweep.sv
// Directed bench for prm_edge_sweep with a one-code, one-mask checker model.
module tb_prm_edge_sweep;

    logic        clk;
    logic        rst;
    logic [14:0] sample_code;
    logic [7:0]  chk_mask;
    logic        hit_en;
    logic [14:0] hit_code;
    logic [7:0]  hit_mask;

    int          total;
    int          bad;
    int          nsamp;
    int          lat;
    logic [14:0] samples [0:31];
    logic        seen_valid;

    prm_edge_sweep_if #(.NUM_OBS(8)) bus ();

    prm_edge_sweep #(.NUM_OBS(8), .JBITS(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .sample_code (sample_code),
        .chk_mask    (chk_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        chk_mask = 8'h00;
        if (hit_en && sample_code == hit_code) chk_mask = hit_mask;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where res_valid is seen.
    task automatic do_req(input logic [14:0] s, input logic [14:0] e);
        nsamp = 0;
        check("accept_ready", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_start = s;
        bus.req_end   = e;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_start = ~s;
        bus.req_end   = ~e;
        lat = 1;
        while (!bus.res_valid && lat < 20) begin
            samples[nsamp] = sample_code;
            nsamp++;
            @(negedge clk);
            lat++;
        end
        if (!bus.res_valid) check("timeout", 32'd0, 32'd1);
    endtask

    task automatic release_res();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("release_idle", {30'd0, bus.req_ready, bus.res_valid}, 32'h2);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        hit_en = 1'b0;
        hit_code = '0;
        hit_mask = '0;
        bus.req_valid = 1'b0;
        bus.req_start = '0;
        bus.req_end   = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("rst_code", {17'd0, sample_code}, 32'd0);
        check("rst_res", {20'd0, bus.res_blocked, bus.res_step, bus.res_mask}, 32'd0);

        // reset dominates a coincident request
        bus.req_valid = 1'b1;
        bus.req_start = 15'h1234;
        bus.req_end   = 15'h1234;
        @(negedge clk);
        check("rst_dom_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_dom_code", {17'd0, sample_code}, 32'd0);
        bus.req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // single-sample edge
        do_req(15'h0000, 15'h0000);
        check("one_lat", lat, 32'd2);
        check("one_nsamp", nsamp, 32'd1);
        check("one_res", {20'd0, bus.res_blocked, bus.res_step, bus.res_mask}, 32'd0);
        release_res();

        // full diagonal, free
        do_req(15'h0000, 15'h7FFF);
        check("diag_lat", lat, 32'd9);
        check("diag_nsamp", nsamp, 32'd8);
        for (int i = 0; i < 8; i++) check("diag_code", {17'd0, samples[i]}, i * 32'h1249);
        check("diag_res", {20'd0, bus.res_blocked, bus.res_step, bus.res_mask}, {20'd0, 1'b0, 3'd7, 8'h00});
        release_res();

        // opposite directions on two joints: J4 7->0, J0 0->5
        do_req(15'h7000, 15'h0005);
        check("mix_nsamp", nsamp, 32'd8);
        check("mix_s1", {17'd0, samples[1]}, 32'h6001);
        check("mix_last", {17'd0, samples[7]}, 32'h0005);
        check("mix_res", {20'd0, bus.res_blocked, bus.res_step, bus.res_mask}, {20'd0, 1'b0, 3'd7, 8'h00});
        release_res();

        // obstacle mid-sweep
        hit_en = 1'b1;
        hit_code = 15'h36DB;
        hit_mask = 8'h04;
        do_req(15'h0000, 15'h7FFF);
        check("blk_lat", lat, 32'd5);
        check("blk_nsamp", nsamp, 32'd4);
        check("blk_res", {20'd0, bus.res_blocked, bus.res_step, bus.res_mask}, {20'd0, 1'b1, 3'd3, 8'h04});
        release_res();

        // obstacle on the end sample: blocking wins
        hit_code = 15'h0049;
        hit_mask = 8'h81;
        do_req(15'h0000, 15'h0049);
        check("end_lat", lat, 32'd3);
        check("end_res", {20'd0, bus.res_blocked, bus.res_step, bus.res_mask}, {20'd0, 1'b1, 3'd1, 8'h81});

        // consumer stalls in DONE while a new request is offered
        bus.req_valid = 1'b1;
        bus.req_start = 15'h0001;
        bus.req_end   = 15'h0002;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold", {18'd0, bus.res_valid, bus.req_ready, bus.res_blocked, bus.res_step, bus.res_mask},
                  {18'd0, 1'b1, 1'b0, 1'b1, 3'd1, 8'h81});
        end
        bus.req_valid = 1'b0;
        release_res();
        hit_en = 1'b0;
        do_req(15'h0001, 15'h0002);
        check("after_hold_nsamp", nsamp, 32'd2);
        check("after_hold_res", {20'd0, bus.res_blocked, bus.res_step, bus.res_mask}, {20'd0, 1'b0, 3'd1, 8'h00});

        // hold the blocked result from before, then abort a sweep with reset
        hit_en = 1'b1;
        hit_code = 15'h0049;
        release_res();
        do_req(15'h0000, 15'h0049);
        release_res();
        hit_en = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_start = 15'h0000;
        bus.req_end   = 15'h7FFF;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_code", {17'd0, sample_code}, 32'h2492);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ctrl", {30'd0, bus.req_ready, bus.res_valid}, 32'h2);
        check("abort_code", {17'd0, sample_code}, 32'd0);
        check("abort_res", {20'd0, bus.res_blocked, bus.res_step, bus.res_mask}, 32'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.res_valid || !bus.req_ready) seen_valid = 1'b1;
        end
        check("abort_quiet", {31'd0, seen_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
